// File: rtl/csr_seq_master_pkg.sv
// Shared types for the CSR sequencing master: command opcodes, FSM states
// and the masked compare used by POLL.
package csr_seq_master_pkg;

  typedef enum logic [1:0] {
    OP_WRITE    = 2'd0,
    OP_READ     = 2'd1,
    OP_POLL     = 2'd2,
    OP_WAIT_IRQ = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_A,
    ST_RD_D,
    ST_GAP,
    ST_WIRQ,
    ST_RESP
  } state_e;

  // True when every bit selected by mask agrees between value and expected.
  function automatic logic poll_match(input logic [31:0] value,
                                      input logic [31:0] expected,
                                      input logic [31:0] mask);
    return ((value ^ expected) & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/csr_seq_master.sv
// CSR-bus initiator: takes one command at a time (write, read, poll,
// wait-irq), drives the CSR port and returns one response per command.
// Every output is a flop; the combinational block computes next values.
module csr_seq_master
  import csr_seq_master_pkg::*;
#(
  parameter int CSR_AW    = 14,
  parameter int TIMEOUT_W = 16,
  parameter int POLL_GAP  = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CSR_AW-1:0] cmd_addr,
  input  logic [31:0]       cmd_data,
  input  logic [31:0]       cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic [CSR_AW-1:0] csr_a,
  output logic              csr_we,
  output logic [31:0]       csr_do,
  input  logic [31:0]       csr_di,
  input  logic              irq
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  state_e                state_q, state_nxt;
  op_e                   op_q, op_nxt;
  logic [CSR_AW-1:0]     addr_q, addr_nxt;
  logic [31:0]           data_q, data_nxt;
  logic [31:0]           mask_q, mask_nxt;
  logic [TIMEOUT_W-1:0]  tmo_q, tmo_nxt, tmo_inc;
  logic                  tmo_hit;
  logic [GAP_W-1:0]      gap_q, gap_nxt;
  logic                  cmd_ready_nxt, rsp_valid_nxt, rsp_err_nxt, csr_we_nxt;
  logic [31:0]           rsp_data_nxt, csr_do_nxt;
  logic [CSR_AW-1:0]     csr_a_nxt;

  // Next-state, latched command fields, counters and registered-output values.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
    state_nxt    = state_q;
    op_nxt       = op_q;
    addr_nxt     = addr_q;
    data_nxt     = data_q;
    mask_nxt     = mask_q;
    tmo_nxt      = tmo_q;
    gap_nxt      = gap_q;
    rsp_data_nxt = rsp_data;
    rsp_err_nxt  = rsp_err;
    // The busy-cycle count including the current one; reaching all-ones is the timeout.
    tmo_inc      = tmo_q + 1'b1;
    tmo_hit      = (tmo_inc == '1);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_nxt       = op_e'(cmd_op);
          addr_nxt     = cmd_addr;
          data_nxt     = cmd_data;
          mask_nxt     = cmd_mask;
          tmo_nxt      = '0;
          rsp_data_nxt = 32'd0;
          rsp_err_nxt  = 1'b0;
          case (op_e'(cmd_op))
            OP_WRITE:         state_nxt = ST_WR;
            OP_READ, OP_POLL: state_nxt = ST_RD_A;
            default:          state_nxt = ST_WIRQ;
          endcase
        end
      end
      ST_WR: state_nxt = ST_RESP;
      ST_RD_A: begin
        if (op_q == OP_POLL) begin
          tmo_nxt = tmo_inc;
          if (tmo_hit) begin
            state_nxt   = ST_RESP;
            rsp_err_nxt = 1'b1;
          end else begin
            state_nxt = ST_RD_D;
          end
        end else begin
          state_nxt = ST_RD_D;
        end
      end
      ST_RD_D: begin
        rsp_data_nxt = csr_di;
        if (op_q != OP_POLL) begin
          state_nxt = ST_RESP;
        end else if (poll_match(csr_di, data_q, mask_q)) begin
          // A match on the timeout cycle still counts as success.
          state_nxt = ST_RESP;
        end else if (tmo_hit) begin
          state_nxt   = ST_RESP;
          rsp_err_nxt = 1'b1;
        end else begin
          state_nxt = ST_GAP;
          gap_nxt   = '0;
          tmo_nxt   = tmo_inc;
        end
      end
      ST_GAP: begin
        tmo_nxt = tmo_inc;
        if (tmo_hit) begin
          state_nxt   = ST_RESP;
          rsp_err_nxt = 1'b1;
        end else if (gap_q == GAP_LAST) begin
          state_nxt = ST_RD_A;
        end else begin
          gap_nxt = gap_q + 1'b1;
        end
      end
      ST_WIRQ: begin
        tmo_nxt = tmo_inc;
        if (irq) begin
          state_nxt = ST_RESP;
        end else if (tmo_hit) begin
          state_nxt   = ST_RESP;
          rsp_err_nxt = 1'b1;
        end
      end
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    cmd_ready_nxt = (state_nxt == ST_IDLE);
    rsp_valid_nxt = (state_nxt == ST_RESP);
    csr_we_nxt    = (state_nxt == ST_WR);
    csr_a_nxt     = (state_nxt == ST_WR || state_nxt == ST_RD_A) ? addr_nxt : '0;
    csr_do_nxt    = (state_nxt == ST_WR) ? data_nxt : 32'd0;
  end

  // State, command, counter and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    // NOTE: non-blocking assignments make every register load from pre-edge values, whatever the statement order.
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_WRITE;
      addr_q    <= '0;
      data_q    <= 32'd0;
      mask_q    <= 32'd0;
      tmo_q     <= '0;
      gap_q     <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_err   <= 1'b0;
      csr_a     <= '0;
      csr_we    <= 1'b0;
      csr_do    <= 32'd0;
    end else begin
      state_q   <= state_nxt;
      op_q      <= op_nxt;
      addr_q    <= addr_nxt;
      data_q    <= data_nxt;
      mask_q    <= mask_nxt;
      tmo_q     <= tmo_nxt;
      gap_q     <= gap_nxt;
      cmd_ready <= cmd_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_data  <= rsp_data_nxt;
      rsp_err   <= rsp_err_nxt;
      csr_a     <= csr_a_nxt;
      csr_we    <= csr_we_nxt;
      csr_do    <= csr_do_nxt;
    end
  end

endmodule

// File: tb/tb_csr_seq_master.sv
// Self-checking bench for csr_seq_master: a small CSR slave, an irq driver
// and a timing/value model computed from the command rules.
module tb_csr_seq_master;

  localparam int CSR_AW    = 14;
  localparam int TIMEOUT_W = 4;
  localparam int POLL_GAP  = 4;
  localparam int TMO       = (1 << TIMEOUT_W) - 1;  // busy cycles before timeout
  localparam int PERIOD    = POLL_GAP + 2;          // cycles between poll reads
  localparam int BOUND     = 64;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'd0;
  logic [CSR_AW-1:0] cmd_addr = '0;
  logic [31:0]       cmd_data = 32'd0;
  logic [31:0]       cmd_mask = 32'd0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic [CSR_AW-1:0] csr_a;
  logic              csr_we;
  logic [31:0]       csr_do;
  logic [31:0]       csr_di = 32'd0;
  logic              irq = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  csr_seq_master #(.CSR_AW(CSR_AW), .TIMEOUT_W(TIMEOUT_W), .POLL_GAP(POLL_GAP)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .csr_a(csr_a), .csr_we(csr_we), .csr_do(csr_do), .csr_di(csr_di), .irq(irq)
  );

  always #5 sys_clk = ~sys_clk;

  // Edge counter: after edge k it holds k, so edge k itself sees k-1.
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Slave: 16 plain registers, plus an optional poll register whose value
  // flips from miss to hit once the edge counter reaches poll_t_match.
  logic [31:0]       regs [16];
  logic [31:0]       model_mem [16];
  logic              poll_en = 1'b0;
  logic [CSR_AW-1:0] poll_addr = '0;
  int                poll_t_match = 0;
  logic [31:0]       poll_hit_val = 32'd0;
  logic [31:0]       poll_miss_val = 32'd0;

  always @(posedge sys_clk) begin
    if (csr_we) regs[csr_a[3:0]] <= csr_do;
    if (poll_en && csr_a == poll_addr)
      csr_di <= (cyc >= poll_t_match) ? poll_hit_val : poll_miss_val;
    else
      csr_di <= regs[csr_a[3:0]];
  end

  // Bus monitor: idle/response cycles must show no CSR activity; also logs
  // write strobes and the cycles at which the monitored address is read.
  int                we_cnt = 0;
  logic [CSR_AW-1:0] mon_addr = '0;
  int                read_cyc[$];

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (csr_we) we_cnt++;
      if (!csr_we && mon_addr != '0 && csr_a == mon_addr) read_cyc.push_back(cyc);
      if (cmd_ready || rsp_valid) begin
        n_checks++;
        if (csr_we !== 1'b0 || csr_a !== '0) begin
          n_fail++;
          $display("FAIL bus_quiet: csr_we=%b csr_a=%h while idle/resp, required 0/0", csr_we, csr_a);
        end
      end
    end
  end

  // Offer one command and return the edge index N at which it was accepted.
  task automatic send(input logic [1:0] op, input logic [CSR_AW-1:0] addr,
                      input logic [31:0] data, input logic [31:0] mask, output int n);
    int waited = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
    while (!cmd_ready && waited < BOUND) begin @(negedge sys_clk); waited++; end
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: cmd_ready=0 after %0d cycles, required 1", waited);
    end
    @(negedge sys_clk);
    // Scramble the command bus so only latched fields can be in use.
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom_range(3, 0));
    cmd_addr  = CSR_AW'($urandom);
    cmd_data  = $urandom;
    cmd_mask  = $urandom;
    n = cyc;
  endtask

  // Wait for the response, check latency/value, hold it for stall cycles, then consume it.
  task automatic collect_rsp(input string name, input int n, input int exp_lat,
                             input logic [31:0] exp_data, input logic exp_err, input int stall);
    int waited = 0;
    int lat;
    while (!rsp_valid && waited < BOUND) begin @(negedge sys_clk); waited++; end
    n_checks++;
    if (!rsp_valid) begin
      n_fail++;
      $display("FAIL %s rsp_timeout: rsp_valid=0 after %0d cycles, required 1", name, waited);
      return;
    end
    lat = cyc - n;
    n_checks++;
    if (lat != exp_lat) begin
      n_fail++; $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (rsp_data !== exp_data || rsp_err !== exp_err) begin
      n_fail++;
      $display("FAIL %s rsp: data=%h err=%b, required data=%h err=%b", name, rsp_data, rsp_err, exp_data, exp_err);
    end
    repeat (stall) begin
      @(negedge sys_clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_err !== exp_err || cmd_ready !== 1'b0 ||
          csr_we !== 1'b0 || csr_a !== '0) begin
        n_fail++;
        $display("FAIL %s stall: valid=%b data=%h err=%b ready=%b we=%b a=%h, required 1/%h/%b/0/0/0",
                 name, rsp_valid, rsp_data, rsp_err, cmd_ready, csr_we, csr_a, exp_data, exp_err);
      end
    end
    rsp_ready = 1'b1;
    @(negedge sys_clk);
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s handshake: rsp_valid=%b cmd_ready=%b, required 0/1", name, rsp_valid, cmd_ready);
    end
  endtask

  task automatic check_reset_values(input string name);
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_err !== 1'b0 ||
        csr_a !== '0 || csr_we !== 1'b0 || csr_do !== 32'd0) begin
      n_fail++;
      $display("FAIL %s: ready=%b valid=%b data=%h err=%b a=%h we=%b do=%h, required 1/0/0/0/0/0/0",
               name, cmd_ready, rsp_valid, rsp_data, rsp_err, csr_a, csr_we, csr_do);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    check_reset_values("reset_held");
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check_reset_values("reset_released");
  endtask

  task automatic test_write(input logic [CSR_AW-1:0] addr, input logic [31:0] data, input int stall);
    int n;
    int we0 = we_cnt;
    send(2'd0, addr, data, $urandom, n);
    n_checks++;
    if (csr_we !== 1'b1 || csr_a !== addr || csr_do !== data) begin
      n_fail++;
      $display("FAIL write_bus: we=%b a=%h do=%h, required 1/%h/%h", csr_we, csr_a, csr_do, addr, data);
    end
    collect_rsp("write", n, 1, 32'd0, 1'b0, stall);
    n_checks++;
    if (we_cnt - we0 != 1) begin
      n_fail++; $display("FAIL write_strobes: got %0d cycles of csr_we, required 1", we_cnt - we0);
    end
    model_mem[addr[3:0]] = data;
  endtask

  // Read data is captured at edge N+2, so rsp_valid is seen right after it.
  task automatic test_read(input logic [CSR_AW-1:0] addr, input int stall);
    int n;
    logic [31:0] exp_v;
    exp_v = model_mem[addr[3:0]];
    send(2'd1, addr, $urandom, $urandom, n);
    n_checks++;
    if (csr_a !== addr || csr_we !== 1'b0) begin
      n_fail++; $display("FAIL read_addr: a=%h we=%b, required %h/0", csr_a, csr_we, addr);
    end
    @(negedge sys_clk);
    n_checks++;
    if (csr_a !== '0) begin
      n_fail++; $display("FAIL read_addr_hold: a=%h one cycle later, required 0", csr_a);
    end
    collect_rsp("read", n, 2, exp_v, 1'b0, stall);
  endtask

  // The poll register matches from slave-visible edge count N+off onward.
  // Reads happen every PERIOD cycles; the first read at or after off wins
  // if its capture lands within the timeout, otherwise the last miss is returned.
  task automatic test_poll(input logic [CSR_AW-1:0] addr, input logic [31:0] data, input logic [31:0] mask,
                           input logic [31:0] hit_v, input logic [31:0] miss_v, input int off, input int stall);
    int n, j, cap, exp_lat, reads;
    logic [31:0] exp_d;
    logic exp_e;
    poll_addr = addr; poll_hit_val = hit_v; poll_miss_val = miss_v;
    poll_t_match = 32'h7fff_ffff; poll_en = 1'b1;
    mon_addr = addr;
    read_cyc.delete();
    send(2'd2, addr, data, mask, n);
    poll_t_match = n + off;
    j   = (off + PERIOD - 1) / PERIOD;
    cap = 2 + j * PERIOD;
    if (cap <= TMO) begin
      exp_lat = cap; exp_d = hit_v; exp_e = 1'b0; reads = j + 1;
    end else begin
      exp_lat = TMO; exp_d = miss_v; exp_e = 1'b1; reads = (TMO - 1) / PERIOD + 1;
    end
    collect_rsp("poll", n, exp_lat, exp_d, exp_e, stall);
    if (addr != '0) begin
      n_checks++;
      if (read_cyc.size() != reads) begin
        n_fail++; $display("FAIL poll_reads: got %0d reads, required %0d", read_cyc.size(), reads);
      end else begin
        foreach (read_cyc[k]) begin
          n_checks++;
          if (read_cyc[k] - n != k * PERIOD) begin
            n_fail++;
            $display("FAIL poll_spacing: read %0d at +%0d, required +%0d", k, read_cyc[k] - n, k * PERIOD);
          end
        end
      end
    end
    poll_en = 1'b0; mon_addr = '0;
  endtask

  // irq first sampled high at edge N+k; k > TMO means it never rises in time.
  task automatic test_wait_irq(input int k, input int stall);
    int n, waited;
    irq = (k <= 1);
    send(2'd3, CSR_AW'($urandom), $urandom, $urandom, n);
    waited = 0;
    while (!rsp_valid && waited < BOUND) begin
      irq = (cyc - n + 1 >= k);
      @(negedge sys_clk);
      waited++;
    end
    irq = 1'b0;
    if (k <= TMO) collect_rsp("wait_irq", n, k, 32'd0, 1'b0, stall);
    else          collect_rsp("wait_irq_timeout", n, TMO, 32'd0, 1'b1, stall);
  endtask

  task automatic test_reset_mid_poll();
    int n;
    int seen = 0;
    poll_addr = 14'h0123; poll_hit_val = 32'd0; poll_miss_val = 32'hdead_beef;
    poll_t_match = 32'h7fff_ffff; poll_en = 1'b1;
    send(2'd2, 14'h0123, 32'd0, 32'hffff_ffff, n);
    while (cyc < n + 3) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check_reset_values("reset_mid_poll");
    sys_rst = 1'b0;
    poll_en = 1'b0;
    repeat (20) begin
      @(negedge sys_clk);
      if (rsp_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL reset_no_rsp: rsp_valid seen %0d cycles after abort, required 0", seen);
    end
  endtask

  task automatic test_random(input int iters);
    for (int i = 0; i < iters; i++) begin
      int op;
      int stall;
      op    = $urandom_range(3, 0);
      stall = $urandom_range(3, 0);
      case (op)
        0: test_write(CSR_AW'($urandom), $urandom, stall);
        1: test_read(CSR_AW'($urandom), stall);
        2: begin
          logic [31:0] data, mask, flip, hit_v, miss_v;
          int b;
          data   = $urandom;
          mask   = $urandom;
          b      = $urandom_range(31, 0);
          flip   = 32'd1 << b;
          mask   = mask | flip;
          miss_v = ((data ^ flip) & mask) | ($urandom & ~mask);
          hit_v  = (data & mask) | ($urandom & ~mask);
          test_poll(CSR_AW'($urandom_range(16383, 1)), data, mask, hit_v, miss_v,
                    $urandom_range(20, 0), stall);
        end
        default: test_wait_irq($urandom_range(20, 1), stall);
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin regs[i] = 32'd0; model_mem[i] = 32'd0; end
    test_reset();
    test_write(14'h0001, 32'h0000_000b, 0);
    test_write(14'h0002, 32'h0000_0010, 0);
    test_read(14'h0002, 0);
    test_read(14'h0002, 10);                  // response held under backpressure
    // Poll address 0, bit0 clears between the 2nd and 3rd read.
    test_poll(14'h0000, 32'd0, 32'd1, 32'h0000_0004, 32'h0000_0005, 10, 0);
    test_poll(14'h0040, 32'h0000_0000, 32'h0000_0001, 32'h0, 32'h1, 1000, 0);  // poll timeout
    test_wait_irq(5, 0);
    test_wait_irq(1, 0);                       // irq already high on entry
    test_wait_irq(TMO, 0);                     // success on the timeout cycle
    test_wait_irq(100, 0);                     // never rises
    test_reset_mid_poll();
    test_write(14'h0003, 32'h1234_5678, 0);
    test_read(14'h0003, 0);
    test_random(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
